pc_fetch_ctrl: RTL and testbench

//  Program-counter / fetch-control stage. Holds the architectural PC, drives the

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_fetch_ctrl_if.sv | 33 +++
 rtl/pc_next_sel.sv | 23 ++
 rtl/pc_fetch_ctrl.sv | 79 +++++++
 tb/tb_pc_fetch_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and widths for the fetch stage, instruction decoder and branch-target LUT.
package pc_pkg;

   localparam int unsigned PC_W      = 10;
   localparam int unsigned LUT_IDX_W = 4;
   localparam int unsigned RET_W     = 16;

   typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;

   typedef enum logic [1:0] {SEL_HOLD, SEL_SEQ, SEL_ABS, SEL_REL} pc_sel_t;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bundle: run control, decoded branch/halt fields, LUT lookup and PC outputs.
interface pc_fetch_ctrl_if
   import pc_pkg::*;
#(
   parameter int unsigned D     = PC_W,
   parameter int unsigned CNT_W = RET_W
);

   logic                 start;
   logic                 stall;
   logic                 halt;
   logic                 branch_en;
   logic                 branch_taken;
   logic                 branch_rel;
   logic [LUT_IDX_W-1:0] branch_idx;
   logic [LUT_IDX_W-1:0] lut_addr;
   logic [D-1:0]         lut_target;
   logic [D-1:0]         pc;
   logic                 fetch_valid;
   logic                 done;
   logic [CNT_W-1:0]     retired;

   modport master (
      output start, stall, halt, branch_en, branch_taken, branch_rel, branch_idx, lut_target,
      input  lut_addr, pc, fetch_valid, done, retired
   );

   modport slave (
      input  start, stall, halt, branch_en, branch_taken, branch_rel, branch_idx, lut_target,
      output lut_addr, pc, fetch_valid, done, retired
   );

endinterface

// File: rtl/pc_next_sel.sv
// Pure combinational next-PC selector; all sums wrap modulo 2**D with the carry dropped.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int unsigned D = PC_W
) (
   input  logic [D-1:0] pc,
   input  logic [D-1:0] lut_target,
   input  pc_sel_t      sel,
   output logic [D-1:0] pc_next
);

   always_comb begin
      pc_next = pc;
      unique case (sel)
         SEL_SEQ:  pc_next = pc + D'(1);
         SEL_ABS:  pc_next = lut_target;
         SEL_REL:  pc_next = pc + lut_target;
         default:  pc_next = pc;
      endcase
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch control: run FSM, next-PC selection and retired-instruction count.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int unsigned D     = PC_W,
   parameter int unsigned CNT_W = RET_W
) (
   input  logic            clk,
   input  logic            reset,
   pc_fetch_ctrl_if.slave  bus
);

   pc_state_t        state_q, state_d;
   logic [D-1:0]     pc_q, pc_d, pc_next;
   logic [CNT_W-1:0] retired_q, retired_d;
   pc_sel_t          sel;
   logic             restart;

   pc_next_sel #(
      .D (D)
   ) u_next_sel (
      .pc         (pc_q),
      .lut_target (bus.lut_target),
      .sel        (sel),
      .pc_next    (pc_next)
   );

   // Stall wins over everything; a halt still retires but holds the PC.
   always_comb begin
      state_d   = state_q;
      sel       = SEL_HOLD;
      retired_d = retired_q;
      restart   = 1'b0;
      unique case (state_q)
         IDLE, HALT: begin
            if (bus.start) begin
               state_d = RUN;
               restart = 1'b1;
            end
         end
         RUN: begin
            if (!bus.stall) begin
               retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
               if (bus.halt) begin
                  state_d = HALT;
               end else if (bus.branch_en && bus.branch_taken) begin
                  sel = bus.branch_rel ? SEL_REL : SEL_ABS;
               end else begin
                  sel = SEL_SEQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (restart) begin
         retired_d = '0;
      end
      pc_d = restart ? '0 : pc_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
      end
   end

   assign bus.lut_addr    = bus.branch_idx;
   assign bus.pc          = pc_q;
   assign bus.fetch_valid = (state_q == RUN);
   assign bus.done        = (state_q == HALT);
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; a second instance with a 4-bit counter covers saturation.
module tb_pc_fetch_ctrl;
   import pc_pkg::*;

   localparam int unsigned D = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl_if #(.D(D), .CNT_W(16)) bus ();
   pc_fetch_ctrl_if #(.D(D), .CNT_W(4))  bus_s ();

   assign bus_s.start        = bus.start;
   assign bus_s.stall        = bus.stall;
   assign bus_s.halt         = bus.halt;
   assign bus_s.branch_en    = bus.branch_en;
   assign bus_s.branch_taken = bus.branch_taken;
   assign bus_s.branch_rel   = bus.branch_rel;
   assign bus_s.branch_idx   = bus.branch_idx;
   assign bus_s.lut_target   = bus.lut_target;

   pc_fetch_ctrl #(
      .D     (D),
      .CNT_W (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pc_fetch_ctrl #(
      .D     (D),
      .CNT_W (4)
   ) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start        = 1'b0;
      bus.stall        = 1'b0;
      bus.halt         = 1'b0;
      bus.branch_en    = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_rel   = 1'b0;
      bus.branch_idx   = '0;
      bus.lut_target   = '0;
   endtask

   task automatic branch(input logic taken, input logic rel, input logic [3:0] idx,
                         input logic [D-1:0] target);
      bus.branch_en    = 1'b1;
      bus.branch_taken = taken;
      bus.branch_rel   = rel;
      bus.branch_idx   = idx;
      bus.lut_target   = target;
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      #12 reset = 1'b1;

      // 1: out of reset, no start
      repeat (5) tick();
      check_eq("t1_pc", bus.pc, 0);
      check_eq("t1_fetch_valid", bus.fetch_valid, 0);
      check_eq("t1_retired", bus.retired, 0);
      check_eq("t1_done", bus.done, 0);

      // 2: start, sequential fetch, then stall
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("t2_pc_start", bus.pc, 0);
      check_eq("t2_fetch_valid", bus.fetch_valid, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq("t2_pc_seq", bus.pc, i);
      end
      check_eq("t2_retired", bus.retired, 4);
      bus.stall = 1'b1;
      branch(1'b1, 1'b0, 4'd5, 10'd99);
      tick();
      tick();
      check_eq("t2_pc_stall", bus.pc, 4);
      check_eq("t2_retired_stall", bus.retired, 4);
      idle_inputs();

      // 3: absolute taken branch
      branch(1'b1, 1'b0, 4'd2, 10'd44);
      #1 check_eq("t3_lut_addr", bus.lut_addr, 2);
      tick();
      check_eq("t3_pc_abs", bus.pc, 44);
      check_eq("t3_retired", bus.retired, 5);

      // 4: relative branches and wrap
      branch(1'b1, 1'b0, 4'd1, 10'd4);
      tick();
      check_eq("t4_pc_setup", bus.pc, 4);
      branch(1'b1, 1'b1, 4'd3, 10'h3FF);
      tick();
      check_eq("t4_pc_rel_neg", bus.pc, 3);
      branch(1'b1, 1'b0, 4'd1, 10'd1023);
      tick();
      check_eq("t4_pc_top", bus.pc, 1023);
      branch(1'b1, 1'b1, 4'd6, 10'd2);
      tick();
      check_eq("t4_pc_rel_wrap", bus.pc, 1);
      branch(1'b1, 1'b0, 4'd1, 10'd1023);
      tick();
      idle_inputs();
      tick();
      check_eq("t4_pc_seq_wrap", bus.pc, 0);
      check_eq("t4_retired", bus.retired, 11);

      // 5: not-taken branch (start ignored in RUN), halt beats branch, restart
      branch(1'b1, 1'b0, 4'd1, 10'd7);
      tick();
      check_eq("t5_pc_setup", bus.pc, 7);
      branch(1'b0, 1'b0, 4'd1, 10'd300);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("t5_pc_not_taken", bus.pc, 8);
      check_eq("t5_retired_not_taken", bus.retired, 13);
      branch(1'b1, 1'b0, 4'd1, 10'd44);
      bus.halt = 1'b1;
      tick();
      idle_inputs();
      check_eq("t5_pc_halt", bus.pc, 8);
      check_eq("t5_done", bus.done, 1);
      check_eq("t5_fetch_valid_halt", bus.fetch_valid, 0);
      check_eq("t5_retired_halt", bus.retired, 14);
      check_eq("t5_retired_sat", bus_s.retired, 14);
      branch(1'b1, 1'b0, 4'd1, 10'd500);
      tick();
      idle_inputs();
      check_eq("t5_pc_frozen", bus.pc, 8);
      check_eq("t5_retired_frozen", bus.retired, 14);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("t5_pc_restart", bus.pc, 0);
      check_eq("t5_retired_restart", bus.retired, 0);
      check_eq("t5_fetch_valid_restart", bus.fetch_valid, 1);
      check_eq("t5_done_restart", bus.done, 0);

      // 6: asynchronous reset between edges
      branch(1'b1, 1'b0, 4'd1, 10'd20);
      tick();
      idle_inputs();
      check_eq("t6_pc_setup", bus.pc, 20);
      #2 reset = 1'b0;
      #1;
      check_eq("t6_pc_async", bus.pc, 0);
      check_eq("t6_fetch_valid_async", bus.fetch_valid, 0);
      check_eq("t6_retired_async", bus.retired, 0);
      #3 reset = 1'b1;
      tick();
      check_eq("t6_idle_after", bus.fetch_valid, 0);

      // counter saturation on the narrow instance
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (20) tick();
      check_eq("sat_pc", bus.pc, 20);
      check_eq("sat_retired_wide", bus.retired, 20);
      check_eq("sat_retired_narrow", bus_s.retired, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
